// File: rtl/sha3_pkg.sv
// Shared constants and types for the Keccak-f[1600] control path.
//   NR          : number of permutation rounds (width of the one-hot round vector)
//   IDX_W       : width of the binary round index
//   seq_state_e : round sequencer state encoding
//   onehot2bin  : one-hot round vector to binary round index
package sha3_pkg;
  localparam int NR    = 24;
  localparam int IDX_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } seq_state_e;

  // OR-reduce the positions of set bits; exact for one-hot, 0 for all-zero.
  function automatic logic [IDX_W-1:0] onehot2bin(input logic [NR-1:0] oh);
    logic [IDX_W-1:0] b;
    b = '0;
    for (int k = 0; k < NR; k++)
      if (oh[k]) b = b | IDX_W'(k);
    return b;
  endfunction
endpackage

// File: rtl/keccak_round_seq_if.sv
// Handshake and round-control bundle between the absorb control, the round
// sequencer and the permutation datapath.
//   master : requester/consumer side (drives start_valid, stall, out_ready)
//   slave  : the round sequencer (drives everything else)
interface keccak_round_seq_if #(
  parameter int NR    = sha3_pkg::NR,
  parameter int IDX_W = sha3_pkg::IDX_W
);
  logic             start_valid;
  logic             start_ready;
  logic             load_en;
  logic             stall;
  logic             round_en;
  logic [NR-1:0]    round_onehot;
  logic [IDX_W-1:0] round_idx;
  logic             last_round;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport master (
    output start_valid, stall, out_ready,
    input  start_ready, load_en, round_en, round_onehot, round_idx,
           last_round, out_valid, busy
  );

  modport slave (
    input  start_valid, stall, out_ready,
    output start_ready, load_en, round_en, round_onehot, round_idx,
           last_round, out_valid, busy
  );
endinterface

// File: rtl/keccak_round_seq.sv
// Round sequencer for the low-throughput Keccak-f[1600] core.
// Accepts a permutation request (strobing the state load), walks a one-hot
// round vector through NR rounds and presents completion on a valid/ready
// output handshake.
//   clk     : core clock
//   reset_n : synchronous active-low reset
//   bus     : keccak_round_seq_if.slave (start/load, stall, round control,
//             out_valid/out_ready, busy)
module keccak_round_seq
  import sha3_pkg::*;
#(
  parameter int NR    = sha3_pkg::NR,
  parameter int IDX_W = sha3_pkg::IDX_W
) (
  input  logic              clk,
  input  logic              reset_n,
  keccak_round_seq_if.slave bus
);

  seq_state_e       st;
  logic [NR-1:0]    oh;
  logic [IDX_W-1:0] idx;
  logic             start_ready;
  logic             load_en;
  logic             round_en;

  // A HOLD result being consumed frees the sequencer in the same cycle,
  // which is what allows back-to-back permutations with no idle gap.
  assign start_ready = (st == IDLE) | ((st == HOLD) & bus.out_ready);
  assign load_en     = bus.start_valid & start_ready;
  assign round_en    = (st == RUN) & ~bus.stall;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st  <= IDLE;
      oh  <= '0;
      idx <= '0;
    end else begin
      case (st)
        IDLE: if (load_en) begin
          st  <= RUN;
          oh  <= NR'(1);
          idx <= '0;
        end
        RUN: if (round_en) begin
          if (oh[NR-1]) begin
            st  <= HOLD;
            oh  <= '0;
            idx <= '0;
          end else begin
            oh  <= {oh[NR-2:0], 1'b0};
            idx <= idx + IDX_W'(1);
          end
        end
        HOLD: if (bus.out_ready) begin
          if (bus.start_valid) begin
            st  <= RUN;
            oh  <= NR'(1);
            idx <= '0;
          end else begin
            st  <= IDLE;
          end
        end
        default: begin
          st  <= IDLE;
          oh  <= '0;
          idx <= '0;
        end
      endcase
    end
  end

  assign bus.start_ready  = start_ready;
  assign bus.load_en      = load_en;
  assign bus.round_en     = round_en;
  assign bus.round_onehot = oh;
  assign bus.round_idx    = idx;
  // oh is zero outside RUN, so this is naturally low in IDLE/HOLD.
  assign bus.last_round   = oh[NR-1];
  assign bus.out_valid    = (st == HOLD);
  assign bus.busy         = (st != IDLE);

endmodule

// File: doc/keccak_round_seq.md
Name: keccak_round_seq

Overview:
- Round sequencer for the low-throughput Keccak-f[1600] permutation core.
- Accepts a permutation request and strobes the state register load.
- Steps a one-hot round vector through NR rounds; this vector drives the round-constant generator and the round datapath enable.
- Presents completion through a valid/ready output handshake.
- Sits between the padder/absorb control and the permutation datapath.

Parameters:
- NR, 24, number of permutation rounds; width of the one-hot round vector.
- IDX_W, 5, width of the binary round index; must satisfy 2**IDX_W >= NR.

Ports:
- clk  input  1  core clock; all state changes on its rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start_valid  input  1  permutation request; the absorbed block is valid on the datapath input.
- start_ready  output  1  sequencer can accept a request this cycle.
- load_en  output  1  datapath loads the state register this cycle.
- stall  input  1  freezes round progress while high.
- round_en  output  1  datapath applies one round this cycle.
- round_onehot  output  NR  one-hot current round; bit k set during round k; feeds the round-constant generator.
- round_idx  output  IDX_W  binary index of the current round.
- last_round  output  1  round_onehot[NR-1] is set.
- out_valid  output  1  permutation result stable on the datapath.
- out_ready  input  1  consumer takes the result.
- busy  output  1  state is not IDLE.

Behaviour:
- States: IDLE, RUN, HOLD. All are registered.
- Reset (reset_n=0 at a rising edge): state=IDLE, round_onehot=0, round_idx=0. All outputs 0 except start_ready=1.
- Reset mid-RUN or mid-HOLD aborts the operation. No out_valid is produced for the aborted request.
- start_ready = (state==IDLE) | (state==HOLD & out_ready). It is combinational.
- load_en = start_valid & start_ready. It is combinational, asserted in the accept cycle only.
- Accept cycle (load_en=1): next state=RUN, round_onehot<=1 (bit 0), round_idx<=0.
- RUN:
  - round_en = ~stall.
  - When round_en=1 and last_round=0: round_onehot shifts left by 1 and round_idx increments.
  - When round_en=1 and last_round=1: next state=HOLD, round_onehot<=0, round_idx<=0.
  - When stall=1: all registers hold; round_en=0.
  - stall is ignored outside RUN.
- HOLD:
  - out_valid=1. It stays high until out_ready=1; the handshake completes on that cycle.
  - If out_ready=1 and start_valid=0: next state=IDLE.
  - If out_ready=1 and start_valid=1: back-to-back. load_en=1 and next state=RUN with round_onehot=1.
- Outputs in IDLE/HOLD: round_onehot=0, round_en=0, last_round=0.
- Latency without stalls:
  - Accept at cycle 0.
  - round_en high in cycles 1..NR.
  - out_valid first high in cycle NR+1.
  - Each stalled RUN cycle adds exactly one cycle.
- Invariants:
  - round_onehot is one-hot in RUN and zero otherwise.
  - round_idx equals the bit position of round_onehot.
  - round_en is never high outside RUN.
  - load_en and round_en are never high together.
- start_valid outside IDLE/HOLD&out_ready is not accepted. The requester must hold it; it is not lost.

Decomposition:
- Shared package sha3_pkg holds:
  - NR=24 and IDX_W=5 constants;
  - the state encoding (IDLE=2'd0, RUN=2'd1, HOLD=2'd2);
  - a function converting one-hot to binary, used by the bench checker.
- No sub-module is required. The round-constant generator is instantiated by the core top and is driven from round_onehot.

Test Plan:
- Reset, single run: reset_n low for 2 cycles, then start_valid=1 for one cycle, out_ready=1. Expect:
  - load_en pulse at cycle 0;
  - round_onehot = 24'h000001 .. 24'h800000 over cycles 1..24, with round_idx 0..23;
  - last_round at cycle 24;
  - out_valid at cycle 25;
  - start_ready=1 at cycle 25, then IDLE.
- Stalls: stall=1 in cycles 5–7 (round_idx=4). Expect round_onehot held at 24'h000010 and round_en=0 for those 3 cycles; out_valid first at cycle 28.
- Output backpressure: out_ready=0 for 10 cycles after out_valid rises. Expect out_valid held and start_ready=0 throughout; out_ready=1 returns the block to IDLE next cycle.
- Back-to-back: start_valid held high with out_ready=1. Expect load_en at cycles 0 and 25; round_onehot=1 at cycle 26; out_valid at cycles 25 and 50.
- Reset mid-operation: reset_n=0 at cycle 12. Expect next cycle round_onehot=0, busy=0, start_ready=1, and no out_valid afterwards.
- Request during RUN: start_valid=1 at cycle 10. Expect start_ready=0 and load_en=0; the one-hot invariant holds every cycle (checked by assertion).
